sqrt_arbiter: RTL and testbench
===============================

# sqrt_arbiter

Shares one `sqroot_tagged` length unit between `N_REQ` ray-direction requesters. Round-robin arbitration with credit-based flow control keeps in-flight operations within the tag buffer depth. Each completed `TaggedDirection_len` is routed back to its originating requester. The block sits between the per-lane ray generators and the single normalisation sqrt core, and owns that core's `start` input.

## Interface
- `WIDTH`, default `` `WIDTH ``: operand width of `x`.
- `TAG_SIZE`, default 64: tag width carried in `TaggedDirection`.
- `N_REQ`, default 4: number of requesters; must be ≥2.
- `MAX_INFLIGHT`, default 32: credit limit; equals the sqrt unit's tag-FIFO depth.
- `clk`, in, 1: single clock; all logic rising-edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `req_valid`, in, `N_REQ`: requester i presents an operand.
- `req_ready`, out, `N_REQ`: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_x`, in, `N_REQ`×`WIDTH`: squared length per requester.
- `req_td`, in, `N_REQ`×`TaggedDirection`: tag and direction per requester.
- `flush`, in, 1: one-cycle pulse; stop granting and drain.
- `sq_start`, out, 1: connects to sqrt `start`.
- `sq_x`, out, `WIDTH`: connects to sqrt `x_in`.
- `sq_td`, out, `TaggedDirection`: connects to sqrt `TD_in`.
- `sq_valid`, in, 1: sqrt `valid_out`.
- `sq_tdl`, in, `TaggedDirection_len`: sqrt `TDL_out`.
- `rsp_valid`, out, `N_REQ`: one-hot result strobe.
- `rsp_tdl`, out, `TaggedDirection_len`: result bus shared by all requesters.
- `inflight`, out, `$clog2(MAX_INFLIGHT+1)`: outstanding operation count.
- `flush_done`, out, 1: one-cycle pulse when a drain completes.
- `err_underflow`, out, 1: sticky flag; a result arrived with no outstanding id.

## Operation
- **FSM states:**
  - RUN → DRAIN on `flush`.
  - DRAIN → IDLE when `inflight==0`; `flush_done` pulses on that transition.
  - IDLE → RUN on the first cycle with any `req_valid`.
  - Grants are issued only in RUN.
- **Grant:**
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, state and credit.
  - Scan starts at `rr_ptr` and the first valid requester wins.
  - No grant when `inflight==MAX_INFLIGHT`.
  - On a transfer, `rr_ptr` ← (winner+1) mod `N_REQ`.
- **Issue:** on a transfer, register `sq_x`/`sq_td` and assert `sq_start` for exactly one cycle. Push the winner id into the id FIFO at the same time.
- **Return:** on `sq_valid`, pop the id FIFO, register `rsp_tdl` ← `sq_tdl`, and set `rsp_valid[id]` for one cycle. Results return in issue order.
- **Credit:**
  - `inflight` increments on issue and decrements on return.
  - Simultaneous issue and return leaves it unchanged.
  - It never exceeds `MAX_INFLIGHT`.
- **Underflow:** `sq_valid` with an empty id FIFO sets `err_underflow`; the result is dropped and `inflight` stays at 0.
- **No response backpressure:** requesters must accept `rsp_valid` unconditionally.
- **Reset values:**
  - `req_ready`, `sq_start`, `rsp_valid`, `flush_done`, `err_underflow`, `inflight`: 0.
  - `rr_ptr`: 0.
  - State: IDLE.
  - `sq_x`, `sq_td`, `rsp_tdl`: 0.
- **Reset mid-operation:** the id FIFO empties and the credit count clears. The sqrt unit shares `reset`, so no stale results are expected. Any stale result that does arrive is handled by the underflow rule.

## Timing
- Grant is visible in the same cycle as `req_valid`; `sq_start` follows one cycle after the transfer.
- Response latency is one cycle from `sq_valid` to `rsp_valid`. End-to-end latency is the sqrt latency + 2.
- Throughput: one issue per cycle while credits remain.
- `flush` arriving in the same cycle as a transfer: the transfer completes; no further grants are issued.
- `flush` with `inflight==0`: `flush_done` pulses on the next cycle.
- A full credit window followed by a return: a grant may be issued in the same cycle as that return.

## Structure
- `Types.sv` supplies `TaggedDirection` and `TaggedDirection_len`.
- Add `ReqId` (`$clog2(N_REQ)` bits) and the FSM state enum to the shared types file.
- Sub-module `req_id_fifo`:
  - Synchronous FIFO, depth `MAX_INFLIGHT`, width `ReqId`.
  - Push/pop/empty/full.
  - Async active-high reset.
  - Simultaneous push and pop is legal when full or empty-with-push.

## Test plan
- Four requesters continuously valid: grants rotate 0,1,2,3,0. Each `rsp_valid[i]` carries its own tag and `len = sqrt(x)` (e.g. x=16.0 → len=4.0).
- Single requester sends 40 back-to-back with the sqrt stalled (no `sq_valid`): exactly 32 accepted, `inflight=32`, `req_ready=0`. One return → one new grant in the same cycle.
- `flush` while 5 are outstanding: no grants after the flush cycle, all 5 responses delivered, `flush_done` pulses once, state returns to IDLE.
- Issue and return in the same cycle at `inflight=10`: `inflight` stays 10 and the id FIFO order is preserved.
- `sq_valid` with nothing outstanding: `err_underflow`=1 (sticky), no `rsp_valid`.
- `reset` asserted with 8 outstanding: all outputs go to reset values immediately, `inflight=0`, and arbitration resumes at requester 0.

Source files
------------

// File: rtl/sqrt_arbiter_pkg.sv
// Shared types for the sqrt arbiter: tagged direction payloads, requester id and FSM state.
// Operands and lengths are Q16.16; the direction components ride along untouched.
package sqrt_arbiter_pkg;

    localparam int X_W       = 32;
    localparam int TAG_W     = 64;
    localparam int DIR_W     = 16;
    localparam int N_REQ_DEF = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DIR_W-1:0] dir_x;
        logic [DIR_W-1:0] dir_y;
        logic [DIR_W-1:0] dir_z;
    } TaggedDirection;

    typedef struct packed {
        TaggedDirection   td;
        logic [X_W-1:0]   len;
    } TaggedDirection_len;

    typedef logic [$clog2(N_REQ_DEF)-1:0] ReqId;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sqrt_arbiter_req_id_fifo.sv
// Order-preserving FIFO of requester ids for operations in flight in the sqrt core.
// A pop on empty is ignored; a push on full is accepted only alongside a pop.
module req_id_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end sharing one tagged sqrt core between N_REQ requesters.
// Credits bound outstanding ops to the core's tag FIFO; results return in issue order.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int WIDTH        = X_W,
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]        req_x,
    input  TaggedDirection [N_REQ-1:0]         req_td,
    input  logic                               flush,
    output logic                               sq_start,
    output logic [WIDTH-1:0]                   sq_x,
    output TaggedDirection                     sq_td,
    input  logic                               sq_valid,
    input  TaggedDirection_len                 sq_tdl,
    output logic [N_REQ-1:0]                   rsp_valid,
    output TaggedDirection_len                 rsp_tdl,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
    output logic                               flush_done,
    output logic                               err_underflow
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);

    arb_state_e      state, state_nxt;
    logic [ID_W-1:0] rr_ptr, win, pop_id;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;
    logic            found, grant_en, issue, ret, fifo_empty, fifo_full;

    assign ret = sq_valid && !fifo_empty;
    // A return in the same cycle frees a credit, so a full window can still grant.
    assign grant_en = (state == ST_RUN) && (!fifo_full || ret);
    assign issue    = grant_en && found;

    always_comb begin
        found     = 1'b0;
        win       = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
        req_ready = '0;
        if (grant_en && found) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        unique case (state)
            ST_IDLE:  if (|req_valid) state_nxt = ST_RUN;
            ST_RUN:   if (flush) state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight == '0) begin
                state_nxt  = ST_IDLE;
                flush_done = 1'b1;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    req_id_fifo #(.DEPTH(MAX_INFLIGHT), .W(ID_W)) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (win),
        .pop       (ret),
        .pop_data  (pop_id),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            sq_start      <= 1'b0;
            sq_x          <= '0;
            sq_td         <= '0;
            rsp_valid     <= '0;
            rsp_tdl       <= '0;
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            sq_start  <= issue;
            rsp_valid <= '0;
            if (issue) begin
                sq_x   <= req_x[win];
                sq_td  <= req_td[win];
                rr_ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
            end
            if (ret) begin
                rsp_valid[pop_id] <= 1'b1;
                rsp_tdl           <= sq_tdl;
            end
            // A stray result is dropped; only the sticky flag records it.
            if (sq_valid && fifo_empty) err_underflow <= 1'b1;
            if (issue && !ret)      inflight <= inflight + CW'(1);
            else if (ret && !issue) inflight <= inflight - CW'(1);
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: acts as the sqrt core, keeps a queue-based reference model
// checked every cycle, and pins key behaviours with hand-computed literals.
module tb_sqrt_arbiter;
    import sqrt_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXF = 32;
    localparam int CW   = $clog2(MAXF + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid, req_ready, rsp_valid;
    logic [N-1:0][X_W-1:0] req_x;
    TaggedDirection [N-1:0] req_td;
    logic flush, sq_start, sq_valid, flush_done, err_underflow;
    logic [X_W-1:0] sq_x;
    TaggedDirection sq_td;
    TaggedDirection_len sq_tdl, rsp_tdl;
    logic [CW-1:0] inflight;

    sqrt_arbiter #(.WIDTH(X_W), .N_REQ(N), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_td(req_td), .flush(flush), .sq_start(sq_start),
        .sq_x(sq_x), .sq_td(sq_td), .sq_valid(sq_valid), .sq_tdl(sq_tdl),
        .rsp_valid(rsp_valid), .rsp_tdl(rsp_tdl), .inflight(inflight),
        .flush_done(flush_done), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Q16.16 square root: sqrt(x * 2^16) in integer arithmetic.
    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] r, t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[31:0];
    endfunction

    typedef struct {
        int             id;
        logic [X_W-1:0] x;
        TaggedDirection td;
    } op_t;

    typedef struct {
        int                 id;
        TaggedDirection_len tdl;
    } rsp_t;

    function automatic TaggedDirection_len tdl_of(input op_t o);
        TaggedDirection_len r;
        r.td  = o.td;
        r.len = isqrt({16'd0, o.x, 16'd0});
        return r;
    endfunction

    // Reference model: 0 idle, 1 run, 2 drain; outstanding ops held in issue order.
    int                 m_st = 0;
    int                 m_rr = 0;
    op_t                mq[$];
    logic               m_sq_start = 1'b0;
    logic [X_W-1:0]     m_sq_x = '0;
    TaggedDirection     m_sq_td = '0;
    logic [N-1:0]       m_rsp_valid = '0;
    TaggedDirection_len m_rsp_tdl = '0;
    logic               m_under = 1'b0;

    int   glog[$];
    rsp_t rlog[$];
    int   fd_cnt = 0;

    int   c_win;
    logic c_ret;
    logic c_fd;
    logic [N-1:0] c_ready;

    always @(negedge clk) begin
        if (reset) begin
            m_st = 0; m_rr = 0; mq.delete();
            m_sq_start = 1'b0; m_sq_x = '0; m_sq_td = '0;
            m_rsp_valid = '0; m_rsp_tdl = '0; m_under = 1'b0;
        end
        chk("sq_start", sq_start, m_sq_start);
        chk("sq_x", sq_x, m_sq_x);
        chk("sq_td", sq_td, m_sq_td);
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        chk("rsp_tdl", rsp_tdl, m_rsp_tdl);
        chk("inflight", inflight, mq.size());
        chk("err_underflow", err_underflow, m_under);

        c_ret = sq_valid && (mq.size() > 0);
        c_win = -1;
        if (m_st == 1 && (mq.size() < MAXF || c_ret))
            for (int k = 0; k < N; k++)
                if (c_win < 0 && req_valid[(m_rr + k) % N]) c_win = (m_rr + k) % N;
        c_ready = '0;
        if (c_win >= 0) c_ready[c_win] = 1'b1;
        c_fd = (m_st == 2) && (mq.size() == 0);
        chk("req_ready", req_ready, c_ready);
        chk("flush_done", flush_done, c_fd);

        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) glog.push_back(i);
            if (rsp_valid[i]) rlog.push_back('{id: i, tdl: rsp_tdl});
        end
        if (flush_done) fd_cnt++;

        if (!reset) begin
            m_rsp_valid = '0;
            if (c_ret) begin
                m_rsp_valid[mq[0].id] = 1'b1;
                m_rsp_tdl = tdl_of(mq[0]);
                void'(mq.pop_front());
            end else if (sq_valid) begin
                m_under = 1'b1;
            end
            m_sq_start = (c_win >= 0);
            if (c_win >= 0) begin
                m_sq_x  = req_x[c_win];
                m_sq_td = req_td[c_win];
                mq.push_back('{id: c_win, x: req_x[c_win], td: req_td[c_win]});
                m_rr = (c_win + 1) % N;
            end
            case (m_st)
                0: if (|req_valid) m_st = 1;
                1: if (flush) m_st = 2;
                2: if (c_fd) m_st = 0;
                default: m_st = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ret_one();
        sq_valid = 1'b1;
        sq_tdl   = tdl_of(mq[0]);
        cyc();
        sq_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int b = 0;
        while (mq.size() > 0 && b < 200) begin
            ret_one();
            b++;
        end
        if (mq.size() > 0) begin
            n_err++;
            $display("FAIL %s: drain timeout, %0d left", nm, mq.size());
        end
    endtask

    task automatic wait_size(input string nm, input int target);
        int b = 0;
        while (mq.size() < target && b < 100) begin
            cyc();
            b++;
        end
        if (mq.size() < target) begin
            n_err++;
            $display("FAIL %s: fill timeout, size %0d want %0d", nm, mq.size(), target);
        end
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int g0, fd0, b;

    initial begin
        req_valid = '0; flush = 1'b0; sq_valid = 1'b0; sq_tdl = '0;
        for (int i = 0; i < N; i++) begin
            req_x[i]        = X_W'(((i + 1) * (i + 1)) << 16);
            req_td[i].tag   = 64'(100 + i);
            req_td[i].dir_x = 16'(i + 1);
            req_td[i].dir_y = 16'(2 * i);
            req_td[i].dir_z = 16'h8000 | 16'(i);
        end
        repeat (3) cyc();
        chk("rst_inflight", inflight, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_sq_start", sq_start, 0);
        chk("rst_err", err_underflow, 0);
        reset = 1'b0;
        cyc();

        // Rotation across four always-valid requesters.
        req_valid = 4'hF;
        b = 0;
        while (glog.size() < 5 && b < 20) begin cyc(); b++; end
        req_valid = '0;
        if (glog.size() < 5) begin
            n_err++;
            $display("FAIL rotate: only %0d grants", glog.size());
        end else begin
            for (int i = 0; i < 5; i++) chk("rotate_order", glog[i], exp_ord[i]);
        end
        drain("rotate");
        cyc();
        if (rlog.size() >= 5) begin
            chk("rsp3_id", rlog[3].id, 3);
            chk("rsp3_tag", rlog[3].tdl.td.tag, 103);
            chk("rsp3_len_4p0", rlog[3].tdl.len, 32'h0004_0000);
            chk("rsp0_len_1p0", rlog[0].tdl.len, 32'h0001_0000);
        end else begin
            n_err++;
            $display("FAIL rotate_rsp: only %0d responses", rlog.size());
        end

        // Credit limit with the core stalled.
        g0 = glog.size();
        req_valid = 4'b0001;
        repeat (40) cyc();
        chk("credit_accepted", glog.size() - g0, 32);
        chk("credit_inflight", inflight, 32);
        chk("credit_ready", req_ready, 0);
        sq_valid = 1'b1;
        sq_tdl   = tdl_of(mq[0]);
        #1;
        chk("credit_ret_grant", req_ready, 4'b0001);
        cyc();
        sq_valid = 1'b0;
        chk("credit_inflight_after", inflight, 32);
        chk("credit_accepted_after", glog.size() - g0, 33);
        req_valid = '0;
        drain("credit");
        cyc();

        // Simultaneous issue and return at ten outstanding.
        req_valid = 4'b0110;
        wait_size("same_cycle", 10);
        sq_valid = 1'b1;
        sq_tdl   = tdl_of(mq[0]);
        cyc();
        sq_valid  = 1'b0;
        req_valid = '0;
        chk("same_cycle_inflight", inflight, 10);
        drain("same_cycle");
        cyc();

        // Flush with nothing outstanding.
        fd0 = fd_cnt;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_empty_done", flush_done, 1);
        cyc();

        // Flush with five outstanding; requester stays valid through the drain.
        fd0 = fd_cnt;
        req_valid = 4'b0100;
        wait_size("flush5", 4);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush5_inflight", inflight, 5);
        g0 = glog.size();
        repeat (3) cyc();
        drain("flush5");
        req_valid = '0;
        repeat (2) cyc();
        chk("flush5_no_grants", glog.size() - g0, 0);
        chk("flush5_done_once", fd_cnt - fd0, 1);

        // Result with nothing outstanding.
        sq_valid = 1'b1;
        sq_tdl   = '1;
        cyc();
        sq_valid = 1'b0;
        chk("under_flag", err_underflow, 1);
        chk("under_no_rsp", rsp_valid, 0);
        chk("under_inflight", inflight, 0);
        cyc();
        chk("under_sticky", err_underflow, 1);

        // Reset with eight outstanding.
        req_valid = 4'b0110;
        wait_size("reset8", 8);
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("rst8_inflight", inflight, 0);
        chk("rst8_sq_start", sq_start, 0);
        chk("rst8_rsp_valid", rsp_valid, 0);
        chk("rst8_err", err_underflow, 0);
        chk("rst8_sq_x", sq_x, 0);
        chk("rst8_ready", req_ready, 0);
        cyc();
        reset = 1'b0;
        g0 = glog.size();
        req_valid = 4'hF;
        b = 0;
        while (glog.size() == g0 && b < 10) begin cyc(); b++; end
        req_valid = '0;
        if (glog.size() == g0) begin
            n_err++;
            $display("FAIL rst8_resume: no grant after reset");
        end else begin
            chk("rst8_resume_at_0", glog[g0], 0);
        end
        drain("reset8");
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
